conv_host: RTL and testbench

Memory-side responder for the convolution engine's bus. It buffers one 64x64 20-bit image loaded over a streaming port and raises `ready` to start the engine. It then serves the engine's zero-wait image reads and its layer-memory reads/writes for banks `csel` 1..5. Once the engine drops `busy`, it streams the final layer-2 bank out over a valid/ready dump port.

---
 rtl/conv_host.sv | 219 +++++++++++++++++++++
 tb/tb_conv_host.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_host.sv
// conv_host: image buffer, layer-bank responder and dump streamer
// serving the convolution engine's memory bus.
module conv_host #(
    parameter int DW        = 20,
    parameter int AW        = 12,
    parameter int IMG_DEPTH = 4096,
    parameter int L1_DEPTH  = 1024,
    parameter int L2_DEPTH  = 2048
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_valid,
    input  logic [DW-1:0] load_data,
    output logic          load_ready,
    output logic          ready,
    input  logic          busy,
    input  logic [AW-1:0] iaddr,
    output logic [DW-1:0] idata,
    input  logic          cwr,
    input  logic [AW-1:0] caddr_wr,
    input  logic [DW-1:0] cdata_wr,
    input  logic          crd,
    input  logic [AW-1:0] caddr_rd,
    output logic [DW-1:0] cdata_rd,
    input  logic [2:0]    csel,
    output logic          dump_valid,
    output logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    input  logic          dump_ready,
    output logic          done,
    output logic          err
);

    localparam int IAW = $clog2(IMG_DEPTH);
    localparam int L1W = $clog2(L1_DEPTH);
    localparam int L2W = $clog2(L2_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HANDOFF,
        S_RUN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [IAW-1:0] r_cnt;
    logic [AW-1:0]  r_dump_addr;
    logic           r_busy_q;
    logic           r_err;

    logic [DW-1:0] r_img   [IMG_DEPTH];
    logic [DW-1:0] r_bank1 [IMG_DEPTH];
    logic [DW-1:0] r_bank2 [IMG_DEPTH];
    logic [DW-1:0] r_bank3 [L1_DEPTH];
    logic [DW-1:0] r_bank4 [L1_DEPTH];
    logic [DW-1:0] r_bank5 [L2_DEPTH];

    logic           w_img_we;
    logic           w_load_first;
    logic [IAW-1:0] w_img_waddr;
    logic           w_dump_fire;
    logic           w_dump_start;
    logic           w_run;
    logic           w_wr_ok;
    logic           w_rd_ok;
    logic           w_err_set;
    logic [DW-1:0]  w_rd_word;

    function automatic logic in_range(input int a, input int d);
        return a < d;
    endfunction

    // Per-bank depth check; csel 0, 6 and 7 select nothing.
    function automatic logic bank_ok(input logic [2:0] sel,
                                     input logic [AW-1:0] a);
        logic ok;
        ok = 1'b0;
        unique case (sel)
            3'd1, 3'd2: ok = in_range(int'(a), IMG_DEPTH);
            3'd3, 3'd4: ok = in_range(int'(a), L1_DEPTH);
            3'd5:       ok = in_range(int'(a), L2_DEPTH);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_img_we     = 1'b0;
        w_load_first = 1'b0;
        w_dump_fire  = 1'b0;
        w_dump_start = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (load_valid) begin
                    w_img_we     = 1'b1;
                    w_load_first = 1'b1;
                    w_next       = S_LOAD;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    w_img_we = 1'b1;
                    if (int'(r_cnt) == IMG_DEPTH - 1) begin
                        w_next = S_HANDOFF;
                    end
                end
            end
            S_HANDOFF: begin
                if (busy) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (r_busy_q && !busy) begin
                    w_dump_start = 1'b1;
                    w_next       = S_DUMP;
                end
            end
            S_DUMP: begin
                if (dump_ready) begin
                    w_dump_fire = 1'b1;
                    if (int'(r_dump_addr) == L2_DEPTH - 1) begin
                        w_next = S_DONE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_img_waddr = w_load_first ? '0 : r_cnt;
    assign w_run       = (r_state == S_RUN);
    assign w_wr_ok     = bank_ok(csel, caddr_wr);
    assign w_rd_ok     = bank_ok(csel, caddr_rd);

    // Reads outside RUN are harmless; stray writes are protocol errors.
    assign w_err_set = w_run ? ((cwr && !w_wr_ok) || (crd && !w_rd_ok))
                             : cwr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt       <= '0;
            r_dump_addr <= '0;
            r_busy_q    <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_busy_q <= busy;
            if (w_img_we) begin
                r_cnt <= w_load_first ? IAW'(1) : r_cnt + IAW'(1);
            end
            if (w_dump_start) begin
                r_dump_addr <= '0;
            end else if (w_dump_fire) begin
                r_dump_addr <= r_dump_addr + AW'(1);
            end
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (w_load_first) begin
                r_err <= 1'b0;
            end
        end
    end

    // Storage is deliberately left unreset so it survives a reset.
    always_ff @(posedge clk) begin
        if (w_img_we) begin
            r_img[w_img_waddr] <= load_data;
        end
        if (w_run && cwr && w_wr_ok) begin
            unique case (csel)
                3'd1:    r_bank1[caddr_wr[IAW-1:0]] <= cdata_wr;
                3'd2:    r_bank2[caddr_wr[IAW-1:0]] <= cdata_wr;
                3'd3:    r_bank3[caddr_wr[L1W-1:0]] <= cdata_wr;
                3'd4:    r_bank4[caddr_wr[L1W-1:0]] <= cdata_wr;
                3'd5:    r_bank5[caddr_wr[L2W-1:0]] <= cdata_wr;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_word = '0;
        unique case (csel)
            3'd1:    w_rd_word = r_bank1[caddr_rd[IAW-1:0]];
            3'd2:    w_rd_word = r_bank2[caddr_rd[IAW-1:0]];
            3'd3:    w_rd_word = r_bank3[caddr_rd[L1W-1:0]];
            3'd4:    w_rd_word = r_bank4[caddr_rd[L1W-1:0]];
            3'd5:    w_rd_word = r_bank5[caddr_rd[L2W-1:0]];
            default: w_rd_word = '0;
        endcase
    end

    assign cdata_rd = (w_run && crd && w_rd_ok) ? w_rd_word : '0;

    assign idata = in_range(int'(iaddr), IMG_DEPTH) ?
                   r_img[iaddr[IAW-1:0]] : '0;

    assign load_ready = (r_state == S_IDLE) || (r_state == S_LOAD);
    assign ready      = (r_state == S_HANDOFF);
    assign dump_valid = (r_state == S_DUMP);
    assign done       = (r_state == S_DONE);
    assign dump_addr  = r_dump_addr;
    assign dump_data  = r_bank5[r_dump_addr[L2W-1:0]];
    assign err        = r_err;

endmodule

// File: tb/tb_conv_host.sv
// tb_conv_host: scoreboard bench for conv_host load, bank access,
// error flag, dump backpressure and mid-load reset.
module tb_conv_host;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_valid;
    logic [19:0] load_data;
    logic        load_ready;
    logic        ready;
    logic        busy;
    logic [11:0] iaddr;
    logic [19:0] idata;
    logic        cwr;
    logic [11:0] caddr_wr;
    logic [19:0] cdata_wr;
    logic        crd;
    logic [11:0] caddr_rd;
    logic [19:0] cdata_rd;
    logic [2:0]  csel;
    logic        dump_valid;
    logic [11:0] dump_addr;
    logic [19:0] dump_data;
    logic        dump_ready;
    logic        done;
    logic        err;

    int n_chk = 0;
    int n_err = 0;

    logic [19:0] sb_q[$];
    logic [19:0] mdl [int];

    conv_host dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .ready      (ready),
        .busy       (busy),
        .iaddr      (iaddr),
        .idata      (idata),
        .cwr        (cwr),
        .caddr_wr   (caddr_wr),
        .cdata_wr   (cdata_wr),
        .crd        (crd),
        .caddr_rd   (caddr_rd),
        .cdata_rd   (cdata_rd),
        .csel       (csel),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_ready (dump_ready),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit bank_ok(input int sel, input int a);
        case (sel)
            1, 2:    return a < 4096;
            3, 4:    return a < 1024;
            5:       return a < 2048;
            default: return 1'b0;
        endcase
    endfunction

    task automatic load_frame(input int n, input logic [19:0] base,
                              input bit stalls);
        for (int i = 0; i < n; i++) begin
            if (stalls && (i % 7 == 3)) begin
                load_valid = 1'b0;
                step();
            end
            if (i == n - 1) chk("ready_early", ready, 0);
            load_valid = 1'b1;
            load_data  = base | 20'(i);
            step();
        end
        load_valid = 1'b0;
    endtask

    task automatic wr(input int sel, input int a, input logic [19:0] d);
        csel     = 3'(sel);
        caddr_wr = 12'(a);
        cdata_wr = d;
        cwr      = 1'b1;
        step();
        cwr = 1'b0;
        if (bank_ok(sel, a)) mdl[sel * 8192 + a] = d;
    endtask

    task automatic rd(input string tag, input int sel, input int a);
        logic [19:0] e;
        int k;
        k = sel * 8192 + a;
        e = (bank_ok(sel, a) && mdl.exists(k)) ? mdl[k] : 20'h0;
        csel     = 3'(sel);
        caddr_rd = 12'(a);
        crd      = 1'b1;
        sb_q.push_back(e);
        #1;
        chk(tag, cdata_rd, sb_q.pop_front());
        crd = 1'b0;
    endtask

    initial begin
        int got;
        bit stalled;

        reset      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        busy       = 1'b0;
        iaddr      = '0;
        cwr        = 1'b0;
        caddr_wr   = '0;
        cdata_wr   = '0;
        crd        = 1'b0;
        caddr_rd   = '0;
        csel       = '0;
        dump_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_dvalid", dump_valid, 0);
        chk("rst_lready", load_ready, 1);
        reset = 1'b1;

        load_frame(4096, 20'h0, 1'b0);
        chk("ready_rise", ready, 1);
        chk("lready_off", load_ready, 0);
        step();
        chk("ready_hold", ready, 1);
        busy = 1'b1;
        step();
        chk("ready_fall", ready, 0);
        chk("err_run0", err, 0);

        iaddr = 12'h7FF;
        #1 chk("idata_7ff", idata, 20'h007FF);
        iaddr = 12'hFFF;
        #1 chk("idata_fff", idata, 20'h00FFF);
        iaddr = 12'h000;
        #1 chk("idata_0", idata, 20'h00000);

        wr(1, 0, 20'h13100);
        wr(3, 1023, 20'hABCDE);
        wr(5, 2047, 20'h00001);
        rd("rt_b1", 1, 0);
        rd("rt_b3", 3, 1023);
        rd("rt_b5", 5, 2047);
        csel     = 3'd5;
        caddr_rd = 12'd2047;
        crd      = 1'b0;
        #1 chk("crd_low", cdata_rd, 0);
        chk("err_clean", err, 0);

        wr(3, 0, 20'h0BEEF);
        wr(3, 1024, 20'hDEAD0);
        chk("err_oob", err, 1);
        rd("oob_alias", 3, 0);
        rd("oob_read", 3, 1024);

        wr(2, 5, 20'h11111);
        csel     = 3'd2;
        caddr_wr = 12'd5;
        cdata_wr = 20'h22222;
        cwr      = 1'b1;
        caddr_rd = 12'd5;
        crd      = 1'b1;
        sb_q.push_back(20'h11111);
        #1 chk("rw_same", cdata_rd, sb_q.pop_front());
        step();
        cwr = 1'b0;
        mdl[2 * 8192 + 5] = 20'h22222;
        rd("rw_after", 2, 5);

        for (int a = 0; a < 2048; a++) wr(5, a, 20'(a));
        for (int a = 0; a < 2048; a++) sb_q.push_back(mdl[5 * 8192 + a]);

        busy = 1'b0;
        step();
        got     = 0;
        stalled = 1'b0;
        for (int c = 0; c < 20000 && got < 2048; c++) begin
            dump_ready = 1'($urandom_range(0, 1));
            #1;
            if (!dump_valid) begin
                chk("dump_valid", dump_valid, 1);
            end else begin
                chk("dump_addr", dump_addr, got);
                if (stalled) chk("dump_hold", dump_data, sb_q[0]);
                if (dump_ready) begin
                    chk("dump_data", dump_data, sb_q.pop_front());
                    got++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                end
            end
            step();
        end
        dump_ready = 1'b0;
        chk("dump_cnt", got, 2048);
        chk("done_rise", done, 1);
        chk("dvalid_off", dump_valid, 0);

        load_valid = 1'b1;
        load_data  = 20'hF0000;
        step();
        chk("done_clr", done, 0);
        chk("err_clr", err, 0);
        chk("lready_new", load_ready, 1);
        for (int i = 1; i < 100; i++) begin
            load_data = 20'hF0000 | 20'(i);
            step();
        end
        load_valid = 1'b0;
        csel       = 3'd5;
        caddr_wr   = 12'd10;
        cdata_wr   = 20'hFFFFF;
        cwr        = 1'b1;
        step();
        cwr = 1'b0;
        chk("err_cwr_load", err, 1);

        reset = 1'b0;
        #1;
        chk("mrst_ready", ready, 0);
        chk("mrst_err", err, 0);
        chk("mrst_lready", load_ready, 1);
        chk("mrst_done", done, 0);
        step();
        reset = 1'b1;

        load_frame(4096, 20'hF0000, 1'b1);
        chk("ready_rise2", ready, 1);
        csel     = 3'd5;
        caddr_rd = 12'd0;
        crd      = 1'b1;
        #1 chk("crd_outside", cdata_rd, 0);
        step();
        crd = 1'b0;
        chk("crd_no_err", err, 0);

        busy = 1'b1;
        step();
        chk("ready_fall2", ready, 0);
        iaddr = 12'd100;
        #1 chk("idata2_100", idata, 20'hF0064);
        iaddr = 12'd4095;
        #1 chk("idata2_fff", idata, 20'hF0FFF);
        rd("keep_b5", 5, 10);
        rd("keep_b1", 1, 0);
        wr(0, 7, 20'h12345);
        chk("err_csel0", err, 1);
        rd("rd_csel6", 6, 0);
        busy = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
